// File: rtl/pda_display_pkg.sv
// Shared types for the pixel-memory display pager.
// Holds the pager FSM encoding and the hex bank geometry.
package pda_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      SHOW
   } page_state_t;

   localparam int HEX_DIGITS = 8;

endpackage

// File: rtl/page_dwell_timer.sv
// Dwell counter for the page currently on display.
// Counts enabled cycles and flags the final cycle of the dwell period.
module page_dwell_timer #(
   parameter int CYCLES = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // clear has priority so a manual step restarts the period
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/hex_page_scheduler.sv
// Pages the 8-digit hex bank through a window of pixel-memory words.
// Fetches one word per page over a read handshake and holds it for a dwell period.
module hex_page_scheduler
   import pda_display_pkg::*;
#(
   parameter int                ADDR_W       = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter int                NUM_PAGES    = 16,
   parameter int                DWELL_CYCLES = 50_000_000,
   parameter int                TIMEOUT      = 15,
   localparam int               PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    halt,
   input  logic                    step,
   output logic                    mem_rd_en,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic [31:0]             mem_rd_data,
   input  logic                    mem_rd_valid,
   output logic [4*HEX_DIGITS-1:0] disp_word,
   output logic [PW-1:0]           page_idx,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   page_state_t             state_q, state_d;
   logic [PW-1:0]           fetch_q, fetch_d;
   logic [PW-1:0]           page_q, page_d;
   logic [4*HEX_DIGITS-1:0] disp_q, disp_d;
   logic                    err_q, err_d;
   logic [TW-1:0]           to_q, to_d;
   logic [PW-1:0]           next_page;
   logic                    dwell_clr;
   logic                    dwell_en;
   logic                    dwell_exp;

   assign next_page = (page_q == PW'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;

   page_dwell_timer #(
      .CYCLES(DWELL_CYCLES)
   ) u_dwell (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (dwell_clr),
      .en_i     (dwell_en),
      .expired_o(dwell_exp)
   );

   // next-state: fetch, wait with timeout, then dwell/halt/step in SHOW
   always_comb begin
      state_d   = state_q;
      fetch_d   = fetch_q;
      page_d    = page_q;
      disp_d    = disp_q;
      err_d     = err_q;
      to_d      = to_q;
      dwell_clr = 1'b1;
      dwell_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            to_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_rd_valid) begin
               disp_d  = mem_rd_data;
               page_d  = fetch_q;
               to_d    = '0;
               state_d = SHOW;
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               page_d  = fetch_q;
               to_d    = '0;
               state_d = SHOW;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         SHOW: begin
            dwell_clr = 1'b0;
            if (halt) begin
               if (step) begin
                  fetch_d   = next_page;
                  dwell_clr = 1'b1;
                  state_d   = REQ;
               end
            end else if (dwell_exp) begin
               fetch_d = next_page;
               state_d = REQ;
            end else begin
               dwell_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         fetch_q <= '0;
         page_q  <= '0;
         disp_q  <= '0;
         err_q   <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         fetch_q <= fetch_d;
         page_q  <= page_d;
         disp_q  <= disp_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign busy        = (state_q == REQ) || (state_q == WAIT);
   assign mem_rd_en   = busy;
   assign mem_addr    = BASE_ADDR + ADDR_W'(fetch_q);
   assign disp_word   = disp_q;
   assign page_idx    = page_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Directed bench for hex_page_scheduler.
// Small-window configuration with a behavioural read port.
module tb_hex_page_scheduler;

   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        halt = 1'b0;
   logic        step = 1'b0;
   logic        mem_rd_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rd_data = '0;
   logic        mem_rd_valid = 1'b0;
   logic [31:0] disp_word;
   logic [1:0]  page_idx;
   logic        busy;
   logic        timeout_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat = 1;
   int          age = 0;
   logic        block_en = 1'b0;
   logic [7:0]  block_addr = 8'h11;
   logic        force_v = 1'b0;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   hex_page_scheduler #(
      .ADDR_W      (8),
      .BASE_ADDR   (8'h10),
      .NUM_PAGES   (3),
      .DWELL_CYCLES(DW),
      .TIMEOUT     (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .step        (step),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_rd_valid(mem_rd_valid),
      .disp_word   (disp_word),
      .page_idx    (page_idx),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // read port model: answers lat cycles after the request cycle
   always @(posedge clk) begin
      #1;
      if (mem_rd_en) age = age + 1;
      else age = 0;
      mem_rd_valid = force_v ||
         (mem_rd_en && (age == lat + 1) &&
          !(block_en && (mem_addr == block_addr)));
      mem_rd_data = force_v ? 32'hDEADBEEF : mem[mem_addr];
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fetch_page(input string tag,
                             input logic [7:0] a,
                             input logic [31:0] w,
                             input logic [1:0] p,
                             input int nb,
                             input logic e);
      int n;
      n = 0;
      while (!mem_rd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req"}, 32'(mem_rd_en), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_cyc"}, 32'(n), 32'(nb));
      check({tag, "_disp"}, disp_word, w);
      check({tag, "_page"}, 32'(page_idx), 32'(p));
      check({tag, "_err"}, 32'(timeout_err), 32'(e));
      n = 0;
      while (!mem_rd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_show_cyc"}, 32'(n), 32'(DW));
   endtask

   initial begin
      int n;
      int reads;
      logic prev;
      logic bad;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'h000000A1;
      mem[8'h11] = 32'h000000B2;
      mem[8'h12] = 32'h000000C3;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'h10);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_disp", disp_word, 32'd0);
      check("rst_page", 32'(page_idx), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;

      // free-run with wrap
      fetch_page("t1p0", 8'h10, 32'hA1, 2'd0, 2, 1'b0);
      fetch_page("t1p1", 8'h11, 32'hB2, 2'd1, 2, 1'b0);
      fetch_page("t1p2", 8'h12, 32'hC3, 2'd2, 2, 1'b0);
      fetch_page("t1p0b", 8'h10, 32'hA1, 2'd0, 2, 1'b0);

      // halt on page 1, then one manual step
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t2_disp", disp_word, 32'hB2);
      check("t2_page", 32'(page_idx), 32'd1);
      halt = 1'b1;
      bad = 1'b0;
      reads = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_rd_en) reads++;
         if (disp_word !== 32'hB2) bad = 1'b1;
      end
      check("t2_halt_rd", 32'(reads), 32'd0);
      check("t2_halt_hold", 32'(bad), 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check("t2_step_req", 32'(mem_rd_en), 32'd1);
      check("t2_step_addr", 32'(mem_addr), 32'h12);
      reads = 1;
      prev = mem_rd_en;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (mem_rd_en && !prev) reads++;
         prev = mem_rd_en;
      end
      check("t2_reads", 32'(reads), 32'd1);
      check("t2_step_disp", disp_word, 32'hC3);
      check("t2_step_page", 32'(page_idx), 32'd2);
      halt = 1'b0;

      // read timeout on address 11
      do_reset();
      block_en = 1'b1;
      fetch_page("t3p0", 8'h10, 32'hA1, 2'd0, 2, 1'b0);
      fetch_page("t3p1", 8'h11, 32'hA1, 2'd1, 4, 1'b1);
      block_en = 1'b0;
      fetch_page("t3p2", 8'h12, 32'hC3, 2'd2, 2, 1'b1);

      // valid on the timeout cycle wins
      lat = 3;
      do_reset();
      fetch_page("t4", 8'h10, 32'hA1, 2'd0, 4, 1'b0);
      lat = 1;

      // reset during WAIT, late valid ignored
      lat = 10;
      do_reset();
      n = 0;
      while (!mem_rd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("t5_in_wait", 32'(busy), 32'd1);
      reset = 1'b1;
      force_v = 1'b1;
      @(negedge clk);
      check("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_disp", disp_word, 32'd0);
      check("t5_rst_page", 32'(page_idx), 32'd0);
      check("t5_rst_addr", 32'(mem_addr), 32'h10);
      reset = 1'b0;
      force_v = 1'b0;
      @(negedge clk);
      check("t5_late_disp", disp_word, 32'd0);
      check("t5_restart_req", 32'(mem_rd_en), 32'd1);
      check("t5_restart_addr", 32'(mem_addr), 32'h10);
      lat = 1;
      fetch_page("t5", 8'h10, 32'hA1, 2'd0, 2, 1'b0);

      // halt on the expiry cycle; step without halt
      do_reset();
      n = 0;
      while (!mem_rd_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_show", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      halt = 1'b1;
      reads = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_rd_en) reads++;
      end
      check("t6_halt_rd", 32'(reads), 32'd0);
      check("t6_halt_page", 32'(page_idx), 32'd0);
      halt = 1'b0;
      @(negedge clk);
      check("t6_resume_req", 32'(mem_rd_en), 32'd1);
      check("t6_resume_addr", 32'(mem_addr), 32'h11);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_page", 32'(page_idx), 32'd1);
      check("t6_disp", disp_word, 32'hB2);
      n = 0;
      step = 1'b1;
      while (!mem_rd_en && n < 50) begin
         @(negedge clk);
         step = 1'b0;
         n++;
      end
      check("t6_step_ignored", 32'(n), 32'(DW));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
